btn_mode_ctrl: RTL and testbench

- Controller that sits downstream of the debounce stage.
- Takes one debounced button level and classifies each gesture as a short press, a double click or a long press.
- Sequences a 4-state LED mode register: OFF, ON, SLOW blink, FAST blink.
- Drives the board LED directly and exposes 1-cycle gesture pulses for other consumers.

---
 rtl/btn_mode_ctrl_if.sv | 21 ++
 rtl/btn_mode_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_btn_mode_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/btn_mode_ctrl_if.sv
// Button/mode bundle: debounced button level in, gesture pulses, mode and LED out.
interface btn_mode_ctrl_if;
    logic       i_btn_stable;
    logic       o_short;
    logic       o_double;
    logic       o_long;
    logic [1:0] o_mode;
    logic       o_led;

    // Producer of the button level, consumer of gestures/mode/LED.
    modport master (
        output i_btn_stable,
        input  o_short, o_double, o_long, o_mode, o_led
    );

    // The controller itself.
    modport slave (
        input  i_btn_stable,
        output o_short, o_double, o_long, o_mode, o_led
    );
endinterface

// File: rtl/btn_mode_ctrl.sv
// Gesture classifier (short / double / long) driving a 4-state LED mode register
// and the board LED (off, on, slow blink, fast blink).
module btn_mode_ctrl #(
    parameter int unsigned LONG_TICKS   = 100000000,
    parameter int unsigned DCLICK_TICKS = 30000000,
    parameter int unsigned SLOW_TICKS   = 50000000,
    parameter int unsigned FAST_TICKS   = 12500000,
    parameter int unsigned CNT_W        = 27
) (
    input  logic            i_clk,
    input  logic            i_reset,
    btn_mode_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS1,
        ST_WAIT2,
        ST_PRESS2,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_t;

    // Counter starts at 0 in the cycle after the qualifying edge, so the last
    // decision cycle of a window of N ticks sees a count of N-2; the pulse
    // register then makes the pulse visible exactly N cycles after the edge.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 2);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 2);
    localparam logic [CNT_W-1:0] SLOW_LAST   = CNT_W'(SLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] FAST_LAST   = CNT_W'(FAST_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_old_q;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    mode_t            mode_q, mode_d;
    mode_t            mode_seen_q;
    logic [CNT_W-1:0] blink_q, blink_d;
    logic             led_q, led_d;

    logic rise, fall;

    assign rise = bus.i_btn_stable & ~btn_old_q;
    assign fall = ~bus.i_btn_stable & btn_old_q;

    assign bus.o_short  = short_q;
    assign bus.o_double = double_q;
    assign bus.o_long   = long_q;
    assign bus.o_mode   = mode_q;
    assign bus.o_led    = led_q;

    // Gesture FSM: classify press/release timing into one pulse per gesture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESS1;
                    cnt_d   = '0;
                end
            end
            ST_PRESS1: begin
                // A release in the terminal cycle still takes the short path.
                if (fall) begin
                    state_d = ST_WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT2: begin
                if (rise) begin
                    state_d = ST_PRESS2;
                end else if (cnt_q == DCLICK_LAST) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    double_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Mode update, committed on the same edge that raises the gesture pulse.
    always_comb begin
        mode_d = mode_q;
        if (short_d) begin
            mode_d = (mode_q == MODE_OFF) ? MODE_ON : MODE_OFF;
        end else if (double_d) begin
            mode_d = (mode_q == MODE_SLOW) ? MODE_FAST : MODE_SLOW;
        end else if (long_d) begin
            mode_d = MODE_OFF;
        end
    end

    // LED drive: lags the mode by one cycle; blink phase restarts on mode entry.
    always_comb begin
        led_d   = led_q;
        blink_d = blink_q;
        if (mode_q != mode_seen_q) begin
            blink_d = '0;
            led_d   = (mode_q != MODE_OFF);
        end else begin
            case (mode_q)
                MODE_OFF: begin
                    led_d   = 1'b0;
                    blink_d = '0;
                end
                MODE_ON: begin
                    led_d   = 1'b1;
                    blink_d = '0;
                end
                MODE_SLOW: begin
                    if (blink_q == SLOW_LAST) begin
                        led_d   = ~led_q;
                        blink_d = '0;
                    end else begin
                        blink_d = blink_q + CNT_ONE;
                    end
                end
                default: begin
                    if (blink_q == FAST_LAST) begin
                        led_d   = ~led_q;
                        blink_d = '0;
                    end else begin
                        blink_d = blink_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // State, counters and outputs; previous button level resets high so a
    // button held through reset must be released before it counts.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            btn_old_q   <= 1'b1;
            short_q     <= 1'b0;
            double_q    <= 1'b0;
            long_q      <= 1'b0;
            mode_q      <= MODE_OFF;
            mode_seen_q <= MODE_OFF;
            blink_q     <= '0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_old_q   <= bus.i_btn_stable;
            short_q     <= short_d;
            double_q    <= double_d;
            long_q      <= long_d;
            mode_q      <= mode_d;
            mode_seen_q <= mode_q;
            blink_q     <= blink_d;
            led_q       <= led_d;
        end
    end

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Bench for btn_mode_ctrl: gesture table, hand-written corner sequences and
// random button activity, all checked cycle by cycle against a timestamp model.
module tb_btn_mode_ctrl;

    localparam int L = 20;
    localparam int D = 8;
    localparam int S = 6;
    localparam int F = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    btn_mode_ctrl_if bus ();

    btn_mode_ctrl #(
        .LONG_TICKS   (L),
        .DCLICK_TICKS (D),
        .SLOW_TICKS   (S),
        .FAST_TICKS   (F),
        .CNT_W        (27)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int t      = 0;

    // Reference model: gesture tracked as timestamps of its edges.
    int   m_prev  = 1;
    int   p1      = -1;   // cycle of first rise, -1 when no gesture
    int   r1      = -1;   // cycle of first release
    int   p2      = -1;   // cycle of second rise
    bit   longed  = 1'b0;
    int   m_mode  = 0;
    int   m_entry = 0;    // first cycle the current mode was visible
    logic e_short = 1'b0, e_double = 1'b0, e_long = 1'b0, e_led = 1'b0;
    logic [1:0] e_mode = 2'd0;

    // Observation of the current gesture.
    logic [2:0] seen;
    int         g0;
    int         plat;

    typedef struct {
        string      name;
        int         hold1;
        int         gap;
        int         hold2;
        logic [2:0] exp_p;     // {short, double, long}
        logic [1:0] exp_mode;
        int         exp_lat;   // pulse cycle minus first-press cycle
    } vec_t;

    vec_t vec [11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    endtask

    task automatic model_step(input logic b, input logic r);
        logic rise, fall, ps, pd, pl, led_n;
        int nm;
        ps = 1'b0; pd = 1'b0; pl = 1'b0;
        if (r) begin
            m_prev = 1; p1 = -1; r1 = -1; p2 = -1; longed = 1'b0;
            m_mode = 0; m_entry = t + 1;
            e_short = 1'b0; e_double = 1'b0; e_long = 1'b0;
            e_mode = 2'd0; e_led = 1'b0;
            return;
        end
        case (m_mode)
            0:       led_n = 1'b0;
            1:       led_n = 1'b1;
            2:       led_n = (((t - m_entry) / S) % 2) == 0;
            default: led_n = (((t - m_entry) / F) % 2) == 0;
        endcase
        rise = b && (m_prev == 0);
        fall = !b && (m_prev == 1);
        if (p1 < 0) begin
            if (rise) p1 = t;
        end else if (longed) begin
            if (fall) begin p1 = -1; longed = 1'b0; end
        end else if (r1 < 0) begin
            if (fall) r1 = t;
            else if (t - p1 == L - 1) begin pl = 1'b1; longed = 1'b1; end
        end else if (p2 < 0) begin
            if (rise) p2 = t;
            else if (t - r1 == D - 1) begin ps = 1'b1; p1 = -1; r1 = -1; end
        end else begin
            if (fall) begin pd = 1'b1; p1 = -1; r1 = -1; p2 = -1; end
        end
        m_prev = b ? 1 : 0;
        nm = m_mode;
        if (ps)      nm = (m_mode == 0) ? 1 : 0;
        else if (pd) nm = (m_mode == 2) ? 3 : 2;
        else if (pl) nm = 0;
        if (nm != m_mode) m_entry = t + 1;
        m_mode   = nm;
        e_short  = ps;
        e_double = pd;
        e_long   = pl;
        e_mode   = 2'(nm);
        e_led    = led_n;
    endtask

    // One clock: drive, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic b, input logic r, input string tag);
        bus.i_btn_stable = b;
        rst = r;
        model_step(b, r);
        @(posedge clk);
        #1;
        t++;
        chk({tag, ".cycle"},
            int'({bus.o_short, bus.o_double, bus.o_long, bus.o_mode, bus.o_led}),
            int'({e_short, e_double, e_long, e_mode, e_led}));
        seen = seen | {bus.o_short, bus.o_double, bus.o_long};
        if ((bus.o_short | bus.o_double | bus.o_long) && plat < 0) plat = t - g0;
    endtask

    task automatic gesture(input int h1, input int gap, input int h2, input int settle,
                           input string tag);
        seen = 3'b000; plat = -1; g0 = t;
        repeat (h1) step(1'b1, 1'b0, tag);
        if (gap > 0) begin
            repeat (gap) step(1'b0, 1'b0, tag);
            repeat (h2) step(1'b1, 1'b0, tag);
        end
        repeat (settle) step(1'b0, 1'b0, tag);
    endtask

    initial begin
        logic [23:0] pat_slow;
        logic [15:0] pat_fast;
        logic        lvl;

        vec[0]  = '{"short_on",    5, 0, 0, 3'b100, 2'd1, 13};
        vec[1]  = '{"short_off",   5, 0, 0, 3'b100, 2'd0, 13};
        vec[2]  = '{"dbl_slow",    3, 4, 3, 3'b010, 2'd2, 11};
        vec[3]  = '{"dbl_fast",    3, 4, 3, 3'b010, 2'd3, 11};
        vec[4]  = '{"dbl_gapmax",  3, 7, 3, 3'b010, 2'd2, 14};
        vec[5]  = '{"long30",     30, 0, 0, 3'b001, 2'd0, 20};
        vec[6]  = '{"hold19",     19, 0, 0, 3'b100, 2'd1, 27};
        vec[7]  = '{"hold20",     20, 0, 0, 3'b001, 2'd0, 20};
        vec[8]  = '{"short_on2",   5, 0, 0, 3'b100, 2'd1, 13};
        vec[9]  = '{"dbl_from_on", 3, 4, 3, 3'b010, 2'd2, 11};
        vec[10] = '{"short_slow",  5, 0, 0, 3'b100, 2'd0, 13};

        pat_slow = 24'b111111_000000_111111_000000;
        pat_fast = 16'b1100_1100_1100_1100;
        seen = 3'b000; plat = -1; g0 = 0;

        // Reset state.
        repeat (3) step(1'b0, 1'b1, "reset");
        chk("reset.mode",   int'(bus.o_mode), 0);
        chk("reset.led",    int'(bus.o_led), 0);
        chk("reset.pulses", int'({bus.o_short, bus.o_double, bus.o_long}), 0);
        repeat (2) step(1'b0, 1'b0, "idle");

        // Gesture table.
        for (int i = 0; i < 11; i++) begin
            gesture(vec[i].hold1, vec[i].gap, vec[i].hold2, 12, vec[i].name);
            chk({vec[i].name, ".pulse"}, int'(seen), int'(vec[i].exp_p));
            chk({vec[i].name, ".mode"},  int'(bus.o_mode), int'(vec[i].exp_mode));
            chk({vec[i].name, ".lat"},   plat, vec[i].exp_lat);
        end

        // SLOW blink: 6 high, 6 low from the cycle after the mode change.
        gesture(3, 4, 3, 1, "blink_slow");
        chk("blink_slow.dbl",  int'(bus.o_double), 1);
        chk("blink_slow.mode", int'(bus.o_mode), 2);
        for (int k = 0; k < 24; k++) begin
            step(1'b0, 1'b0, "blink_slow");
            chk("blink_slow.led", int'(bus.o_led), int'(pat_slow[23 - k]));
        end

        // FAST blink: 2 high, 2 low.
        gesture(3, 4, 3, 1, "blink_fast");
        chk("blink_fast.mode", int'(bus.o_mode), 3);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b0, "blink_fast");
            chk("blink_fast.led", int'(bus.o_led), int'(pat_fast[15 - k]));
        end

        // Long press clears the mode; release afterwards adds nothing.
        gesture(30, 0, 0, 12, "long_clear");
        chk("long_clear.pulse", int'(seen), 1);
        chk("long_clear.mode",  int'(bus.o_mode), 0);

        // Reset while waiting for a second click.
        gesture(5, 0, 0, 12, "pre_rst");
        gesture(3, 0, 0, 3, "rst_wait2");
        repeat (2) step(1'b0, 1'b1, "rst_wait2");
        seen = 3'b000;
        repeat (12) step(1'b0, 1'b0, "rst_wait2");
        chk("rst_wait2.pulse", int'(seen), 0);
        chk("rst_wait2.mode",  int'(bus.o_mode), 0);
        chk("rst_wait2.led",   int'(bus.o_led), 0);

        // Button held through reset release is ignored until released once.
        repeat (3) step(1'b1, 1'b0, "held_rst");
        repeat (3) step(1'b1, 1'b1, "held_rst");
        seen = 3'b000;
        repeat (30) step(1'b1, 1'b0, "held_rst");
        repeat (12) step(1'b0, 1'b0, "held_rst");
        chk("held_rst.pulse", int'(seen), 0);
        gesture(5, 0, 0, 12, "held_rst_after");
        chk("held_rst_after.pulse", int'(seen), 4);
        chk("held_rst_after.mode",  int'(bus.o_mode), 1);

        // Random button activity with occasional resets.
        lvl = 1'b0;
        for (int i = 0; i < 120; i++) begin
            int unsigned len;
            len = $urandom_range(1, 28);
            lvl = ~lvl;
            for (int unsigned k = 0; k < len; k++)
                step(lvl, ($urandom_range(0, 199) == 0), "rand");
        end
        repeat (12) step(1'b0, 1'b0, "rand_tail");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
